fifo_frame_packer: RTL and testbench



---
 rtl/frame_pkg.sv | 32 +++
 rtl/fifo_frame_packer_if.sv | 22 ++
 rtl/fifo_frame_packer.sv | 171 +++++++++++++++++
 tb/tb_fifo_frame_packer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - state type, sync defaults and checksum helper for fifo_frame_packer (FRAME_SEQ_EN adds ST_SEQ)
package frame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_LEN,
`ifdef FRAME_SEQ_EN
        ST_SEQ,
`endif
        ST_RD_REQ,
        ST_RD_CAP,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    localparam logic [7:0] SYNC0_DEF = 8'hAA;
    localparam logic [7:0] SYNC1_DEF = 8'h55;

`ifdef FRAME_SEQ_EN
    localparam int HDR_LEN = 4;
`else
    localparam int HDR_LEN = 3;
`endif

    // Carries out of bit 7 are dropped on purpose: the checksum is a mod-256 sum.
    function automatic logic [7:0] csum8_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/fifo_frame_packer_if.sv
// rtl/fifo_frame_packer_if.sv - FIFO read port and framed byte stream between packer and its neighbours
interface fifo_frame_packer_if;
    logic        fifo_rd;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic [15:0] fifo_cnt;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;

    modport master (
        output fifo_rd, out_data, out_valid, busy, frame_done,
        input  fifo_dout, fifo_empty, fifo_cnt, out_ready
    );

    modport slave (
        input  fifo_rd, out_data, out_valid, busy, frame_done,
        output fifo_dout, fifo_empty, fifo_cnt, out_ready
    );
endinterface

// File: rtl/fifo_frame_packer.sv
// rtl/fifo_frame_packer.sv - drains one payload from the byte FIFO and emits sync/len/[seq]/payload/csum frames
// FRAME_SEQ_EN inserts an 8-bit frame sequence byte after LEN.
module fifo_frame_packer
    import frame_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 32,
    parameter logic [7:0] SYNC0       = SYNC0_DEF,
    parameter logic [7:0] SYNC1       = SYNC1_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_frame_packer_if.master   bus
);

    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 255) begin : g_len_check
        $error("fifo_frame_packer: PAYLOAD_LEN must be within 1..255");
    end

    localparam logic [7:0]  LEN8     = 8'(PAYLOAD_LEN);
    localparam logic [15:0] LEN16    = 16'(PAYLOAD_LEN);
    localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       fifo_rd_q, fifo_rd_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
`ifdef FRAME_SEQ_EN
    logic [7:0] seq_q, seq_d;
`endif

    logic accept;
    assign accept = out_valid_q && bus.out_ready;

    // fifo_rd is registered, so the strobe for RD_REQ is decided one cycle ahead.
    // This is safe because the packer is the FIFO's only reader: non-empty cannot turn empty meanwhile.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        fifo_rd_d    = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
`ifdef FRAME_SEQ_EN
        seq_d        = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.fifo_cnt >= LEN16) begin
                    state_d     = ST_SYNC0;
                    csum_d      = 8'h00;
                    idx_d       = 8'h00;
                    out_data_d  = SYNC0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_SYNC0: begin
                if (accept) begin
                    state_d    = ST_SYNC1;
                    out_data_d = SYNC1;
                end
            end
            ST_SYNC1: begin
                if (accept) begin
                    state_d    = ST_LEN;
                    out_data_d = LEN8;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    csum_d = csum8_add(csum_q, LEN8);
`ifdef FRAME_SEQ_EN
                    state_d    = ST_SEQ;
                    out_data_d = seq_q;
`else
                    state_d     = ST_RD_REQ;
                    out_valid_d = 1'b0;
                    fifo_rd_d   = !bus.fifo_empty;
`endif
                end
            end
`ifdef FRAME_SEQ_EN
            ST_SEQ: begin
                if (accept) begin
                    csum_d      = csum8_add(csum_q, seq_q);
                    state_d     = ST_RD_REQ;
                    out_valid_d = 1'b0;
                    fifo_rd_d   = !bus.fifo_empty;
                end
            end
`endif
            ST_RD_REQ: begin
                if (fifo_rd_q) state_d = ST_RD_CAP;
                else           fifo_rd_d = !bus.fifo_empty;
            end
            ST_RD_CAP: begin
                out_data_d  = bus.fifo_dout;
                out_valid_d = 1'b1;
                csum_d      = csum8_add(csum_q, bus.fifo_dout);
                state_d     = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = 8'h00;
                        state_d    = ST_CSUM;
                        out_data_d = csum_q;
                    end else begin
                        idx_d       = idx_q + 8'd1;
                        state_d     = ST_RD_REQ;
                        out_valid_d = 1'b0;
                        fifo_rd_d   = !bus.fifo_empty;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
`ifdef FRAME_SEQ_EN
                    seq_d        = seq_q + 8'd1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 8'h00;
            csum_q       <= 8'h00;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            fifo_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FRAME_SEQ_EN
            seq_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            fifo_rd_q    <= fifo_rd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef FRAME_SEQ_EN
            seq_q        <= seq_d;
`endif
        end
    end

    assign bus.fifo_rd    = fifo_rd_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb/tb_fifo_frame_packer.sv - self-checking bench: FIFO model, frame reference model, vector table and corner sequences
module tb_fifo_frame_packer;
    import frame_pkg::*;

    localparam int PLEN = 32;
`ifdef FRAME_SEQ_EN
    localparam bit HAS_SEQ = 1'b1;
`else
    localparam bit HAS_SEQ = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string      name;
        logic [7:0] base;
        logic [7:0] step;
        bit         rnd_data;
        bit         rnd_ready;
        int         exp_csum;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_frame_packer_if bus();

    fifo_frame_packer #(.PAYLOAD_LEN(PLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bq_t        fq;
    bq_t        rx;
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    int         stab_err = 0;
    int         rd_empty_err = 0;
    logic       rd_prev = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rand_ready = 1'b0;
    logic [7:0] exp_seq = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void drive_fifo();
        bus.fifo_cnt   = 16'(fq.size());
        bus.fifo_empty = (fq.size() == 0);
    endfunction

    function automatic void push(input logic [7:0] b);
        fq.push_back(b);
        drive_fifo();
    endfunction

    // Reference frame built straight from the frame definition.
    function automatic bq_t build_frame(input bq_t pl, input logic [7:0] seq);
        bq_t f;
        int  s;
        f = {};
        f.push_back(SYNC0_DEF);
        f.push_back(SYNC1_DEF);
        f.push_back(8'(PLEN));
        s = PLEN;
        if (HAS_SEQ) begin
            f.push_back(seq);
            s += int'(seq);
        end
        foreach (pl[i]) s += int'(pl[i]);
        foreach (pl[i]) f.push_back(pl[i]);
        f.push_back(8'(s % 256));
        return f;
    endfunction

    // One clock: FIFO model reacts to last cycle's read, then this cycle's outputs are observed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) prev_stall = 1'b0;
        if (rd_prev && fq.size() > 0) bus.fifo_dout = fq.pop_front();
        else                          bus.fifo_dout = 8'h00;
        drive_fifo();
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stab_err++;
        if (bus.fifo_rd) begin
            rd_cnt++;
            if (bus.fifo_empty) rd_empty_err++;
        end
        if (bus.frame_done) done_cnt++;
        if (bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        rd_prev    = bus.fifo_rd;
    endtask

    task automatic run_until_done(input string name, input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_frame_done_count"}, done_cnt, target);
    endtask

    task automatic compare_stream(input string name, input bq_t exp);
        int bad;
        int lim;
        bad = 0;
        lim = (rx.size() < exp.size()) ? rx.size() : exp.size();
        chk({name, "_stream_len"}, rx.size(), exp.size());
        for (int i = 0; i < lim; i++) if (rx[i] !== exp[i]) bad++;
        chk({name, "_stream_bytes_bad"}, bad, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_fifo_rd"}, int'(bus.fifo_rd), 0);
        chk({name, "_out_data"}, int'(bus.out_data), 0);
        chk({name, "_out_valid"}, int'(bus.out_valid), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_frame_done"}, int'(bus.frame_done), 0);
    endtask

    vec_t vt[5];

    initial begin
        bq_t pl;
        bq_t exp;
        bq_t tmp;
        int  n;

        vt[0] = '{"ramp",       8'h01, 8'h01, 1'b0, 1'b0, 'h30};
        vt[1] = '{"all_ff",     8'hFF, 8'h00, 1'b0, 1'b0, 'h00};
        vt[2] = '{"ramp_stall", 8'h01, 8'h01, 1'b0, 1'b1, 'h30};
        vt[3] = '{"zeros",      8'h00, 8'h00, 1'b0, 1'b1, 'h20};
        vt[4] = '{"random",     8'h00, 8'h00, 1'b1, 1'b1, -1};

        bus.fifo_dout  = 8'h00;
        bus.fifo_cnt   = 16'h0000;
        bus.fifo_empty = 1'b1;
        bus.out_ready  = 1'b1;

        rst = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        foreach (vt[v]) begin
            rx = {};
            rd_cnt = 0;
            done_cnt = 0;
            rand_ready = vt[v].rnd_ready;
            pl = {};
            for (int i = 0; i < PLEN; i++)
                pl.push_back(vt[v].rnd_data ? 8'($urandom_range(0, 255)) : 8'(vt[v].base + 8'(i) * vt[v].step));
            exp = build_frame(pl, exp_seq);
            foreach (pl[i]) push(pl[i]);
            run_until_done(vt[v].name, 1);
            compare_stream(vt[v].name, exp);
            chk({vt[v].name, "_hdr_plus_len"}, rx.size(), HDR_LEN + PLEN + 1);
            chk({vt[v].name, "_fifo_rd_pulses"}, rd_cnt, PLEN);
            chk({vt[v].name, "_fifo_cnt_end"}, int'(bus.fifo_cnt), 0);
            if (vt[v].exp_csum >= 0 && rx.size() > 0)
                chk({vt[v].name, "_csum"}, int'(rx[rx.size() - 1]),
                    (vt[v].exp_csum + (HAS_SEQ ? int'(exp_seq) : 0)) % 256);
            repeat (2) tick();
            chk({vt[v].name, "_busy_after"}, int'(bus.busy), 0);
            chk({vt[v].name, "_valid_after"}, int'(bus.out_valid), 0);
            exp_seq = exp_seq + 8'd1;
        end

        // One byte short of a payload: nothing may start.
        rx = {};
        rd_cnt = 0;
        done_cnt = 0;
        rand_ready = 1'b0;
        pl = {};
        for (int i = 0; i < PLEN; i++) pl.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < PLEN - 1; i++) push(pl[i]);
        repeat (20) tick();
        chk("cnt31_fifo_rd", rd_cnt, 0);
        chk("cnt31_out_valid", int'(bus.out_valid), 0);
        chk("cnt31_busy", int'(bus.busy), 0);
        push(pl[PLEN - 1]);
        tick();
        chk("cnt32_busy_next_cycle", int'(bus.busy), 1);
        chk("cnt32_valid_next_cycle", int'(bus.out_valid), 1);
        exp = build_frame(pl, exp_seq);
        run_until_done("cnt32", 1);
        compare_stream("cnt32", exp);
        exp_seq = exp_seq + 8'd1;
        repeat (2) tick();

        // Reset after the 10th payload byte has been accepted.
        rx = {};
        rd_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < PLEN; i++) push(8'(i + 1));
        n = 0;
        while (rx.size() < HDR_LEN + 10 && n < 1000) begin
            tick();
            n++;
        end
        chk("abort_reached_byte10", int'(rx.size() >= HDR_LEN + 10), 1);
        rst = 1'b1;
        tick();
        check_idle_outputs("abort");
        rst = 1'b0;
        exp_seq = 8'h00;
        chk("abort_bytes_left", fq.size(), PLEN - 10);
        rd_cnt = 0;
        repeat (30) tick();
        chk("abort_no_restart_busy", int'(bus.busy), 0);
        chk("abort_no_restart_rd", rd_cnt, 0);
        rx = {};
        done_cnt = 0;
        for (int i = 0; i < 10; i++) push(8'(8'h21 + 8'(i)));
        tmp = fq;
        exp = build_frame(tmp, exp_seq);
        run_until_done("after_abort", 1);
        compare_stream("after_abort", exp);
        exp_seq = exp_seq + 8'd1;
        repeat (2) tick();

        // Two payloads queued at once with random backpressure: frames must follow back-to-back.
        rx = {};
        rd_cnt = 0;
        done_cnt = 0;
        rand_ready = 1'b1;
        pl = {};
        for (int i = 0; i < 2 * PLEN; i++) pl.push_back(8'($urandom_range(0, 255)));
        foreach (pl[i]) push(pl[i]);
        tmp = pl[0:PLEN-1];
        exp = build_frame(tmp, exp_seq);
        tmp = pl[PLEN:2*PLEN-1];
        exp = {exp, build_frame(tmp, exp_seq + 8'd1)};
        run_until_done("b2b", 2);
        compare_stream("b2b", exp);
        chk("b2b_fifo_rd_pulses", rd_cnt, 2 * PLEN);
        repeat (2) tick();

        chk("stable_while_stalled", stab_err, 0);
        chk("no_read_when_empty", rd_empty_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
